hsv_to_rgb_pipe: RTL

Pipelined HSV-to-RGB converter closing the HSV effect chain. Effect blocks such as the green-screen keyer operate on packed HSV pixels. This block returns the stream to packed 8:8:8 RGB for the VGA/D8M output path. It is fully pipelined at one pixel per clock, has no backpressure, and carries the sideband word and a per-pixel enable through the same 4-stage delay.

---
 rtl/hsv_to_rgb_pipe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hsv_to_rgb_pipe.sv
// ============================================================================
//  Module   : hsv_to_rgb_pipe
//  Brief    : 4-stage HSV (9:7:8) to RGB (8:8:8) converter, 1 pixel/clock,
//             with per-pixel bypass and aligned sideband/valid.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hsv_to_rgb_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        in_valid,
   input  logic [23:0] pixel_in,
   input  logic [23:0] pass_in,
   output logic        out_valid,
   output logic [23:0] pixel_out,
   output logic [23:0] pass_thru
);

   localparam logic [8:0]  c_HUE_FULL = 9'd360;
   localparam logic [5:0]  c_SECT_W   = 6'd60;
   localparam logic [24:0] c_X_SCALE  = 25'd1093;   // ~65536/60

   // Travelling controls and bypass data
   logic [3:0]       r_valid;
   logic [3:0][23:0] r_pass;
   logic [2:0]       r_en;
   logic [2:0][23:0] r_raw;

   // Stage 1: hue wrap, sector split, saturation widen
   logic [8:0] w_h_raw, w_h, w_base;
   logic [2:0] w_sector;
   logic [5:0] w_f;
   logic [7:0] w_s8;
   logic [2:0] r1_sector;
   logic [5:0] r1_f;
   logic [7:0] r1_s8, r1_v;

   assign w_h_raw = pixel_in[23:15];
   assign w_h     = (w_h_raw >= c_HUE_FULL) ? (w_h_raw - c_HUE_FULL) : w_h_raw;
   assign w_s8    = {pixel_in[14:8], pixel_in[14]};
   assign w_f     = 6'(w_h - w_base);

   always_comb begin
      w_sector = 3'd0;
      w_base   = 9'd0;
      if (w_h >= 9'd300) begin
         w_sector = 3'd5; w_base = 9'd300;
      end else if (w_h >= 9'd240) begin
         w_sector = 3'd4; w_base = 9'd240;
      end else if (w_h >= 9'd180) begin
         w_sector = 3'd3; w_base = 9'd180;
      end else if (w_h >= 9'd120) begin
         w_sector = 3'd2; w_base = 9'd120;
      end else if (w_h >= 9'd60) begin
         w_sector = 3'd1; w_base = 9'd60;
      end
   end

   // Stage 2: chroma and mirrored in-sector offset
   logic [16:0] w_cfull;
   logic [5:0]  w_ff;
   logic [2:0]  r2_sector;
   logic [5:0]  r2_ff;
   logic [7:0]  r2_c, r2_v;

   assign w_cfull = 17'(r1_v) * 17'(r1_s8) + 17'(r1_v);
   assign w_ff    = r1_sector[0] ? (c_SECT_W - r1_f) : r1_f;

   // Stage 3: secondary component and lightness offset
   logic [24:0] w_xfull;
   logic [2:0]  r3_sector;
   logic [7:0]  r3_c, r3_x, r3_m;

   assign w_xfull = 25'(r2_c) * 25'(r2_ff) * c_X_SCALE;

   // Stage 4: sector mux and offset add
   logic [7:0]  w_r0, w_g0, w_b0, w_r, w_g, w_b;
   logic [23:0] r_pix_out;

   always_comb begin
      w_r0 = 8'd0;
      w_g0 = 8'd0;
      w_b0 = 8'd0;
      case (r3_sector)
         3'd0:    begin w_r0 = r3_c; w_g0 = r3_x; end
         3'd1:    begin w_r0 = r3_x; w_g0 = r3_c; end
         3'd2:    begin w_g0 = r3_c; w_b0 = r3_x; end
         3'd3:    begin w_g0 = r3_x; w_b0 = r3_c; end
         3'd4:    begin w_r0 = r3_x; w_b0 = r3_c; end
         3'd5:    begin w_r0 = r3_c; w_b0 = r3_x; end
         default: ;
      endcase
   end

   // Channel + m never exceeds V, so the 8-bit sums cannot wrap
   assign w_r = w_r0 + r3_m;
   assign w_g = w_g0 + r3_m;
   assign w_b = w_b0 + r3_m;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= '0;
         r_pass    <= '0;
         r_en      <= '0;
         r_raw     <= '0;
         r1_sector <= '0;
         r1_f      <= '0;
         r1_s8     <= '0;
         r1_v      <= '0;
         r2_sector <= '0;
         r2_ff     <= '0;
         r2_c      <= '0;
         r2_v      <= '0;
         r3_sector <= '0;
         r3_c      <= '0;
         r3_x      <= '0;
         r3_m      <= '0;
         r_pix_out <= '0;
      end else begin
         r_valid   <= {r_valid[2:0], in_valid};
         r_pass    <= {r_pass[2:0], pass_in};
         r_en      <= {r_en[1:0], en};
         r_raw     <= {r_raw[1:0], pixel_in};

         r1_sector <= w_sector;
         r1_f      <= w_f;
         r1_s8     <= w_s8;
         r1_v      <= pixel_in[7:0];

         r2_sector <= r1_sector;
         r2_ff     <= w_ff;
         r2_c      <= 8'(w_cfull >> 8);
         r2_v      <= r1_v;

         r3_sector <= r2_sector;
         r3_c      <= r2_c;
         r3_x      <= 8'(w_xfull >> 16);
         r3_m      <= r2_v - r2_c;

         r_pix_out <= r_en[2] ? {w_r, w_g, w_b} : r_raw[2];
      end
   end

   assign out_valid = r_valid[3];
   assign pass_thru = r_pass[3];
   assign pixel_out = r_pix_out;

endmodule

`default_nettype wire
